// File: rtl/sc_statemachine_perdio.sv
// Game-outcome controller for the frog game: tracks lives and level, freezes the
// board after a collision and reports respawn, game-over and win to the rest of the system.
module sc_statemachine_perdio #(
    parameter int unsigned LIVES       = 3,
    parameter int unsigned LIVES_WIDTH = 2,
    parameter int unsigned HIT_TICKS   = 4,
    parameter int unsigned LEVEL_WIDTH = 4,
    parameter int unsigned MAX_LEVEL   = 15
) (
    input  logic                   SC_STATEMACHINE_CLOCK_50,
    input  logic                   SC_STATEMACHINE_RESET_InLow,
    input  logic                   SC_STATEMACHINE_start_InLow,
    input  logic                   SC_STATEMACHINE_tick_In,
    input  logic                   SC_STATEMACHINE_perdio_In,
    input  logic                   SC_STATEMACHINE_gano_In,
    output logic [LIVES_WIDTH-1:0] SC_STATEMACHINE_lives_Out,
    output logic [LEVEL_WIDTH-1:0] SC_STATEMACHINE_level_Out,
    output logic                   SC_STATEMACHINE_freeze_Out,
    output logic                   SC_STATEMACHINE_respawn_Out,
    output logic                   SC_STATEMACHINE_gameover_Out,
    output logic                   SC_STATEMACHINE_win_Out,
    output logic [2:0]             SC_STATEMACHINE_state_Out
);

    localparam int unsigned HitCntWidth = $clog2(HIT_TICKS) + 1;
    localparam logic [LIVES_WIDTH-1:0] LivesInit = LIVES_WIDTH'(LIVES);
    localparam logic [LIVES_WIDTH-1:0] LivesOne  = LIVES_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LevelOne  = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LevelMax  = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [HitCntWidth-1:0] HitLast   = HitCntWidth'(HIT_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StHit  = 3'd2,
        StLose = 3'd3,
        StWin  = 3'd4
    } state_e;

    state_e                 r_state;
    logic [LIVES_WIDTH-1:0] r_lives;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [HitCntWidth-1:0] r_hit_cnt;
    logic                   r_prev_start;
    logic                   r_prev_gano;
    logic                   r_freeze;
    logic                   r_respawn;
    logic                   r_gameover;
    logic                   r_win;

    logic w_start_press;
    logic w_gano_rise;

    assign w_start_press = r_prev_start & ~SC_STATEMACHINE_start_InLow;
    assign w_gano_rise   = SC_STATEMACHINE_gano_In & ~r_prev_gano;

    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or negedge SC_STATEMACHINE_RESET_InLow) begin
        if (!SC_STATEMACHINE_RESET_InLow) begin
            r_state      <= StIdle;
            r_lives      <= LivesInit;
            r_level      <= LevelOne;
            r_hit_cnt    <= '0;
            r_prev_start <= 1'b1;
            r_prev_gano  <= 1'b0;
            r_freeze     <= 1'b1;
            r_respawn    <= 1'b0;
            r_gameover   <= 1'b0;
            r_win        <= 1'b0;
        end else begin
            r_prev_start <= SC_STATEMACHINE_start_InLow;
            r_prev_gano  <= SC_STATEMACHINE_gano_In;
            r_respawn    <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_freeze   <= 1'b1;
                    r_gameover <= 1'b0;
                    r_win      <= 1'b0;
                    if (w_start_press) begin
                        r_state   <= StPlay;
                        r_lives   <= LivesInit;
                        r_level   <= LevelOne;
                        r_freeze  <= 1'b0;
                        r_respawn <= 1'b1;
                    end
                end
                StPlay: begin
                    // Collision is a level and beats a simultaneous goal.
                    if (SC_STATEMACHINE_perdio_In) begin
                        r_freeze <= 1'b1;
                        if (r_lives > LivesOne) begin
                            r_lives   <= r_lives - LivesOne;
                            r_hit_cnt <= '0;
                            r_state   <= StHit;
                        end else begin
                            r_lives    <= '0;
                            r_state    <= StLose;
                            r_gameover <= 1'b1;
                        end
                    end else if (w_gano_rise) begin
                        if (r_level < LevelMax) begin
                            r_level   <= r_level + LevelOne;
                            r_respawn <= 1'b1;
                        end else begin
                            r_state  <= StWin;
                            r_freeze <= 1'b1;
                            r_win    <= 1'b1;
                        end
                    end
                end
                StHit: begin
                    if (SC_STATEMACHINE_tick_In) begin
                        if (r_hit_cnt >= HitLast) begin
                            r_state   <= StPlay;
                            r_freeze  <= 1'b0;
                            r_respawn <= 1'b1;
                        end else begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                    end
                end
                StLose, StWin: begin
                    if (w_start_press) begin
                        r_state    <= StIdle;
                        r_freeze   <= 1'b1;
                        r_gameover <= 1'b0;
                        r_win      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_freeze   <= 1'b1;
                    r_gameover <= 1'b0;
                    r_win      <= 1'b0;
                end
            endcase
        end
    end

    assign SC_STATEMACHINE_lives_Out    = r_lives;
    assign SC_STATEMACHINE_level_Out    = r_level;
    assign SC_STATEMACHINE_freeze_Out   = r_freeze;
    assign SC_STATEMACHINE_respawn_Out  = r_respawn;
    assign SC_STATEMACHINE_gameover_Out = r_gameover;
    assign SC_STATEMACHINE_win_Out      = r_win;
    assign SC_STATEMACHINE_state_Out    = r_state;

endmodule

// File: tb/tb_sc_statemachine_perdio.sv
// Directed bench for sc_statemachine_perdio: vector table plus multi-cycle sequences
// for hit timing, losing all lives, winning at MAX_LEVEL=2 and asynchronous reset.
module tb_sc_statemachine_perdio;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_n = 1'b1;
    logic       tick = 1'b0;
    logic       perdio = 1'b0;
    logic       gano = 1'b0;
    logic [1:0] lives;
    logic [3:0] level;
    logic       freeze;
    logic       respawn;
    logic       gameover;
    logic       win;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sc_statemachine_perdio #(
        .LIVES      (3),
        .LIVES_WIDTH(2),
        .HIT_TICKS  (4),
        .LEVEL_WIDTH(4),
        .MAX_LEVEL  (2)
    ) dut (
        .SC_STATEMACHINE_CLOCK_50    (clk),
        .SC_STATEMACHINE_RESET_InLow (rst_n),
        .SC_STATEMACHINE_start_InLow (start_n),
        .SC_STATEMACHINE_tick_In     (tick),
        .SC_STATEMACHINE_perdio_In   (perdio),
        .SC_STATEMACHINE_gano_In     (gano),
        .SC_STATEMACHINE_lives_Out   (lives),
        .SC_STATEMACHINE_level_Out   (level),
        .SC_STATEMACHINE_freeze_Out  (freeze),
        .SC_STATEMACHINE_respawn_Out (respawn),
        .SC_STATEMACHINE_gameover_Out(gameover),
        .SC_STATEMACHINE_win_Out     (win),
        .SC_STATEMACHINE_state_Out   (state)
    );

    typedef struct {
        logic       sn, t, p, g;
        logic [2:0] st;
        logic [1:0] lv;
        logic [3:0] lvl;
        logic       fz, rs, go, wn;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic sn, input logic t, input logic p, input logic g);
        start_n = sn;
        tick    = t;
        perdio  = p;
        gano    = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".lives"}, int'(lives), 3);
        chk({tag, ".level"}, int'(level), 1);
        chk({tag, ".freeze"}, int'(freeze), 1);
        chk({tag, ".respawn"}, int'(respawn), 0);
        chk({tag, ".gameover"}, int'(gameover), 0);
        chk({tag, ".win"}, int'(win), 0);
    endtask

    initial begin
        int   resp_cnt;
        int   hit_ticks;
        bit   resumed;
        logic t;
        logic [2:0] prev;

        //          sn t  p  g   st lv lvl fz rs go wn
        vecs[0]  = '{1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 3, 1, 0, 1, 0, 0};  // start press
        vecs[2]  = '{0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0, 0};  // collision beats goal
        vecs[5]  = '{0, 1, 0, 0, 2, 2, 1, 1, 0, 0, 0};
        vecs[6]  = '{0, 1, 1, 1, 2, 2, 1, 1, 0, 0, 0};  // ignored while frozen
        vecs[7]  = '{0, 1, 0, 0, 2, 2, 1, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 1, 2, 1, 0, 1, 0, 0};  // 4th tick resumes
        vecs[9]  = '{0, 0, 0, 1, 1, 2, 2, 0, 1, 0, 0};  // goal -> level 2
        vecs[10] = '{0, 0, 0, 1, 1, 2, 2, 0, 0, 0, 0};  // held goal, no recount
        vecs[11] = '{0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 1, 4, 2, 2, 1, 0, 0, 1};  // goal at max -> WIN
        vecs[13] = '{0, 0, 0, 0, 4, 2, 2, 1, 0, 0, 1};
        vecs[14] = '{1, 0, 0, 0, 4, 2, 2, 1, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0};  // first press -> IDLE
        vecs[16] = '{1, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 1, 3, 1, 0, 1, 0, 0};  // second press -> new game

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_vals("reset");

        foreach (vecs[i]) begin
            step(vecs[i].sn, vecs[i].t, vecs[i].p, vecs[i].g);
            chk($sformatf("v%0d.state", i), int'(state), int'(vecs[i].st));
            chk($sformatf("v%0d.lives", i), int'(lives), int'(vecs[i].lv));
            chk($sformatf("v%0d.level", i), int'(level), int'(vecs[i].lvl));
            chk($sformatf("v%0d.freeze", i), int'(freeze), int'(vecs[i].fz));
            chk($sformatf("v%0d.respawn", i), int'(respawn), int'(vecs[i].rs));
            chk($sformatf("v%0d.gameover", i), int'(gameover), int'(vecs[i].go));
            chk($sformatf("v%0d.win", i), int'(win), int'(vecs[i].wn));
        end

        // Held start button must not retrigger.
        resp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            resp_cnt += int'(respawn);
        end
        chk("held_start.respawns", resp_cnt, 0);
        chk("held_start.state", int'(state), 1);

        // Collision held 10 cycles, tick every 5 cycles.
        resp_cnt  = 0;
        hit_ticks = 0;
        resumed   = 1'b0;
        for (int c = 0; c < 60 && !resumed; c++) begin
            t    = (c % 5 == 4);
            prev = state;
            step(1'b0, t, c < 10, 1'b0);
            if (prev == 3'd2 && t) hit_ticks++;
            resp_cnt += int'(respawn);
            if (prev == 3'd2 && state == 3'd1) resumed = 1'b1;
        end
        chk("hit.resumed", int'(resumed), 1);
        chk("hit.ticks_in_hit", hit_ticks, 4);
        chk("hit.respawns", resp_cnt, 1);
        chk("hit.lives", int'(lives), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hit.respawn_drops", int'(respawn), 0);
        chk("hit.still_play", int'(state), 1);

        // Remaining collisions: 2 -> 1 -> 0 and LOSE.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("c2.state", int'(state), 2);
        chk("c2.lives", int'(lives), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("c2.resume", int'(state), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("c3.state", int'(state), 3);
        chk("c3.lives", int'(lives), 0);
        chk("c3.gameover", int'(gameover), 1);
        chk("c3.freeze", int'(freeze), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lose.lives_sat", int'(lives), 0);
        chk("lose.state_held", int'(state), 3);

        // Two presses back to a new game, then win at level 2.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart.idle", int'(state), 0);
        chk("restart.gameover", int'(gameover), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart.play", int'(state), 1);
        chk("restart.lives", int'(lives), 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("win.level2", int'(level), 2);
        chk("win.respawn", int'(respawn), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("win.state", int'(state), 4);
        chk("win.win", int'(win), 1);
        chk("win.level_held", int'(level), 2);

        // Asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_reset.state", int'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
